// File: rtl/complex_mult_pipe_pkg.sv
// rtl/complex_mult_pipe_pkg.sv - shared widths, helper and pipeline slot type for the complex multiplier
package cmult_pkg;

  localparam int CMULT_A_W     = 16;
  localparam int CMULT_B_W     = 16;
  localparam int CMULT_OUT_W   = 16;
  localparam int CMULT_SHIFT   = 15;
  localparam int CMULT_TAG_W   = 8;
  // Slot tag field is sized for the widest sideband any instance may carry.
  localparam int CMULT_TAG_MAX = 32;

  function automatic int cmult_full_w(input int a_w, input int b_w);
    return a_w + b_w + 3;
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [CMULT_TAG_MAX-1:0] tag;
  } cmult_slot_t;

endpackage

// File: rtl/complex_mult_pipe_if.sv
// rtl/complex_mult_pipe_if.sv - input/output stream bundle for complex_mult_pipe
interface complex_mult_pipe_if
  import cmult_pkg::*;
#(
  parameter int A_WIDTH   = CMULT_A_W,
  parameter int B_WIDTH   = CMULT_B_W,
  parameter int OUT_WIDTH = CMULT_OUT_W,
  parameter int TAG_WIDTH = CMULT_TAG_W
);

  logic                        s_valid_i;
  logic                        s_ready_o;
  logic                        conj_i;
  logic signed [A_WIDTH-1:0]   a_real_i;
  logic signed [A_WIDTH-1:0]   a_imag_i;
  logic signed [B_WIDTH-1:0]   b_real_i;
  logic signed [B_WIDTH-1:0]   b_imag_i;
  logic [TAG_WIDTH-1:0]        tag_i;
  logic                        m_valid_o;
  logic                        m_ready_i;
  logic signed [OUT_WIDTH-1:0] y_real_o;
  logic signed [OUT_WIDTH-1:0] y_imag_o;
  logic [TAG_WIDTH-1:0]        tag_o;
  logic                        ovf_o;

  modport slave (
    input  s_valid_i, conj_i, a_real_i, a_imag_i, b_real_i, b_imag_i, tag_i, m_ready_i,
    output s_ready_o, m_valid_o, y_real_o, y_imag_o, tag_o, ovf_o
  );

  modport master (
    output s_valid_i, conj_i, a_real_i, a_imag_i, b_real_i, b_imag_i, tag_i, m_ready_i,
    input  s_ready_o, m_valid_o, y_real_o, y_imag_o, tag_o, ovf_o
  );

endinterface

// File: rtl/complex_mult_pipe_round_sat.sv
// rtl/complex_mult_pipe_round_sat.sv - round-half-up scaling then saturate (CMULT_SAT_EN) or wrap
module cmult_round_sat #(
  parameter int IN_W  = 35,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic signed [EXT_W-1:0] din_ext;
  logic signed [EXT_W-1:0] scaled;

  assign din_ext = EXT_W'(din);

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);
      // Extra headroom bit keeps the rounding bias from wrapping at the positive limit.
      assign scaled = (din_ext + HALF) >>> SHIFT;
    end else begin : g_pass
      assign scaled = din_ext;
    end
  endgenerate

`ifdef CMULT_SAT_EN
  always_comb begin
    dout = scaled[OUT_W-1:0];
    ovf  = 1'b0;
    if (scaled > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      ovf  = 1'b1;
    end else if (scaled < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      ovf  = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^{scaled[EXT_W-1:OUT_W], MAX_V, MIN_V};
  assign dout      = scaled[OUT_W-1:0];
  assign ovf       = 1'b0;
`endif

endmodule

// File: rtl/complex_mult_pipe.sv
// rtl/complex_mult_pipe.sv - 3-stage, 3-multiplier complex multiply y=a*b or a*conj(b)
// Saturating narrowing when CMULT_SAT_EN is defined, two's-complement wrap otherwise.
module complex_mult_pipe
  import cmult_pkg::*;
#(
  parameter int A_WIDTH   = CMULT_A_W,
  parameter int B_WIDTH   = CMULT_B_W,
  parameter int OUT_WIDTH = CMULT_OUT_W,
  parameter int SHIFT     = CMULT_SHIFT,
  parameter int TAG_WIDTH = CMULT_TAG_W
) (
  input logic                 sys_clk_i,
  input logic                 rst_n_i,
  complex_mult_pipe_if.slave  bus
);

  localparam int AE_W   = A_WIDTH + 1;
  localparam int BE_W   = B_WIDTH + 1;
  localparam int PB_W   = B_WIDTH + 2;
  localparam int PROD_W = A_WIDTH + B_WIDTH + 2;
  localparam int FULL_W = cmult_full_w(A_WIDTH, B_WIDTH);

  logic ce;
  assign ce            = !bus.m_valid_o || bus.m_ready_i;
  assign bus.s_ready_o = ce;

  // S1 operand conditioning; b is widened before negation so -min is exact.
  logic signed [AE_W-1:0] a_r_ext, a_i_ext;
  logic signed [BE_W-1:0] b_r_ext, b_i_ext, b_i_cj;

  assign a_r_ext = AE_W'(bus.a_real_i);
  assign a_i_ext = AE_W'(bus.a_imag_i);
  assign b_r_ext = BE_W'(bus.b_real_i);
  assign b_i_ext = BE_W'(bus.b_imag_i);
  assign b_i_cj  = bus.conj_i ? -b_i_ext : b_i_ext;

  logic signed [A_WIDTH-1:0] a_r1;
  logic signed [BE_W-1:0]    b_r1, b_i1;
  logic signed [AE_W-1:0]    pa1, pm1;
  logic signed [PB_W-1:0]    pb1;
  logic signed [PROD_W-1:0]  p0_2, p1_2, p2_2;
  cmult_slot_t               slot1, slot2;

  always_ff @(posedge sys_clk_i) begin
    if (ce) begin
      a_r1 <= bus.a_real_i;
      b_r1 <= b_r_ext;
      b_i1 <= b_i_cj;
      pa1  <= a_r_ext + a_i_ext;
      pm1  <= a_r_ext - a_i_ext;
      pb1  <= PB_W'(b_r_ext) + PB_W'(b_i_cj);
      p0_2 <= PROD_W'(a_r1) * PROD_W'(pb1);
      p1_2 <= PROD_W'(b_i1) * PROD_W'(pa1);
      p2_2 <= PROD_W'(b_r1) * PROD_W'(pm1);
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot1 <= '0;
      slot2 <= '0;
    end else if (ce) begin
      slot1.valid <= bus.s_valid_i;
      slot1.tag   <= CMULT_TAG_MAX'(bus.tag_i);
      slot2       <= slot1;
    end
  end

  generate
    if (TAG_WIDTH < CMULT_TAG_MAX) begin : g_tag_pad
      logic unused_tag;
      assign unused_tag = ^slot2.tag[CMULT_TAG_MAX-1:TAG_WIDTH];
    end
  endgenerate

  // S3: re = ar*br - ai*bi, im = ar*bi + ai*br recovered from the three products.
  logic signed [FULL_W-1:0]    re_full, im_full;
  logic signed [OUT_WIDTH-1:0] re_n, im_n;
  logic                        ovf_re, ovf_im;

  assign re_full = FULL_W'(p0_2) - FULL_W'(p1_2);
  assign im_full = FULL_W'(p0_2) - FULL_W'(p2_2);

  cmult_round_sat #(.IN_W(FULL_W), .OUT_W(OUT_WIDTH), .SHIFT(SHIFT)) u_rs_re (
    .din  (re_full),
    .dout (re_n),
    .ovf  (ovf_re)
  );

  cmult_round_sat #(.IN_W(FULL_W), .OUT_W(OUT_WIDTH), .SHIFT(SHIFT)) u_rs_im (
    .din  (im_full),
    .dout (im_n),
    .ovf  (ovf_im)
  );

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.m_valid_o <= 1'b0;
      bus.y_real_o  <= '0;
      bus.y_imag_o  <= '0;
      bus.tag_o     <= '0;
      bus.ovf_o     <= 1'b0;
    end else if (ce) begin
      bus.m_valid_o <= slot2.valid;
      bus.y_real_o  <= re_n;
      bus.y_imag_o  <= im_n;
      bus.tag_o     <= slot2.tag[TAG_WIDTH-1:0];
      bus.ovf_o     <= ovf_re | ovf_im;
    end
  end

endmodule
